// File: rtl/power_sweep_if.sv
// Handshake and stimulus bundle between the sweep controller and its
// characterisation harness.
interface power_sweep_if #(
  parameter int CNT_W = 8
);
  logic             start_i;
  logic             mode_i;
  logic             abort_i;
  logic [3:0]       vec_o;
  logic             vec_valid_o;
  logic             dut_out_i;
  logic             busy_o;
  logic             done_o;
  logic             res_valid_o;
  logic             res_ready_i;
  logic [CNT_W-1:0] ones_cnt_o;
  logic [CNT_W-1:0] toggle_cnt_o;
  logic [CNT_W-1:0] mismatch_cnt_o;

  modport master (
    output start_i, mode_i, abort_i, dut_out_i, res_ready_i,
    input  vec_o, vec_valid_o, busy_o, done_o, res_valid_o,
    input  ones_cnt_o, toggle_cnt_o, mismatch_cnt_o
  );

  modport slave (
    input  start_i, mode_i, abort_i, dut_out_i, res_ready_i,
    output vec_o, vec_valid_o, busy_o, done_o, res_valid_o,
    output ones_cnt_o, toggle_cnt_o, mismatch_cnt_o
  );
endinterface

// File: rtl/power_sweep_ctrl.sv
// Exhaustive 4-input stimulus sequencer with ones/toggle/mismatch activity
// counters and a valid/ready result port.
module power_sweep_ctrl #(
  parameter int PASSES = 4,
  parameter int CNT_W  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  power_sweep_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [7:0]       LAST_PASS = 8'(PASSES - 1);

  function automatic logic [3:0] order_vec(input logic [3:0] idx, input logic gray);
    return gray ? (idx ^ {1'b0, idx[3:1]}) : idx;
  endfunction

  function automatic logic golden(input logic [3:0] v);
    return ~(v[1] ^ v[2] ^ v[3]) & (v[0] | v[1]);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && (c != CNT_MAX)) ? c + CNT_W'(1) : c;
  endfunction

  state_t           state_q;
  logic             mode_q;
  logic [3:0]       idx_q;
  logic [7:0]       pass_q;
  logic [3:0]       vec_q;
  logic             vec_valid_q;
  logic             busy_q;
  logic             done_q;
  logic             res_valid_q;
  logic             samp_valid_q;
  logic             samp_q;
  logic             samp_exp_q;
  logic             prev_q;
  logic             have_prev_q;
  logic [CNT_W-1:0] ones_q;
  logic [CNT_W-1:0] tog_q;
  logic [CNT_W-1:0] mism_q;

  logic [CNT_W-1:0] ones_d;
  logic [CNT_W-1:0] tog_d;
  logic [CNT_W-1:0] mism_d;
  logic [3:0]       idx_d;
  logic             last_vec_s;

  // Saturating next values for the sample currently held in the sample stage
  always_comb begin
    ones_d     = sat_inc(ones_q, samp_q);
    mism_d     = sat_inc(mism_q, samp_q != samp_exp_q);
    tog_d      = sat_inc(tog_q, have_prev_q && (samp_q != prev_q));
    idx_d      = idx_q + 4'd1;
    last_vec_s = (idx_q == 4'd15) && (pass_q == LAST_PASS);
  end

  // Sweep FSM, sample stage and result counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mode_q       <= 1'b0;
      idx_q        <= 4'd0;
      pass_q       <= 8'd0;
      vec_q        <= 4'd0;
      vec_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      res_valid_q  <= 1'b0;
      samp_valid_q <= 1'b0;
      samp_q       <= 1'b0;
      samp_exp_q   <= 1'b0;
      prev_q       <= 1'b0;
      have_prev_q  <= 1'b0;
      ones_q       <= '0;
      tog_q        <= '0;
      mism_q       <= '0;
    end else if (bus.abort_i) begin
      state_q      <= IDLE;
      idx_q        <= 4'd0;
      pass_q       <= 8'd0;
      vec_q        <= 4'd0;
      vec_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      res_valid_q  <= 1'b0;
      samp_valid_q <= 1'b0;
      have_prev_q  <= 1'b0;
      ones_q       <= '0;
      tog_q        <= '0;
      mism_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start_i) begin
            state_q      <= RUN;
            mode_q       <= bus.mode_i;
            idx_q        <= 4'd0;
            pass_q       <= 8'd0;
            vec_q        <= order_vec(4'd0, bus.mode_i);
            vec_valid_q  <= 1'b1;
            busy_q       <= 1'b1;
            samp_valid_q <= 1'b0;
            have_prev_q  <= 1'b0;
            ones_q       <= '0;
            tog_q        <= '0;
            mism_q       <= '0;
          end
        end
        RUN: begin
          samp_valid_q <= 1'b1;
          samp_q       <= bus.dut_out_i;
          samp_exp_q   <= golden(vec_q);
          if (samp_valid_q) begin
            ones_q      <= ones_d;
            tog_q       <= tog_d;
            mism_q      <= mism_d;
            prev_q      <= samp_q;
            have_prev_q <= 1'b1;
          end
          if (last_vec_s) begin
            state_q     <= DRAIN;
            vec_q       <= 4'd0;
            vec_valid_q <= 1'b0;
          end else begin
            idx_q <= idx_d;
            vec_q <= order_vec(idx_d, mode_q);
            if (idx_q == 4'd15) begin
              pass_q <= pass_q + 8'd1;
            end
          end
        end
        DRAIN: begin
          if (samp_valid_q) begin
            ones_q      <= ones_d;
            tog_q       <= tog_d;
            mism_q      <= mism_d;
            prev_q      <= samp_q;
            have_prev_q <= 1'b1;
          end
          samp_valid_q <= 1'b0;
          state_q      <= REPORT;
          busy_q       <= 1'b0;
          done_q       <= 1'b1;
          res_valid_q  <= 1'b1;
        end
        REPORT: begin
          done_q <= 1'b0;
          if (bus.res_ready_i) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          vec_q       <= 4'd0;
          vec_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.vec_o          = vec_q;
  assign bus.vec_valid_o    = vec_valid_q;
  assign bus.busy_o         = busy_q;
  assign bus.done_o         = done_q;
  assign bus.res_valid_o    = res_valid_q;
  assign bus.ones_cnt_o     = ones_q;
  assign bus.toggle_cnt_o   = tog_q;
  assign bus.mismatch_cnt_o = mism_q;

endmodule

// File: tb/tb_power_sweep_ctrl.sv
// Randomised bench for power_sweep_ctrl against a sweep-level activity model.
module tb_power_sweep_ctrl;

  localparam int PASSES = 3;
  localparam int CNT_W  = 5;
  localparam int N      = 16 * PASSES;
  localparam int SATMAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  power_sweep_if #(.CNT_W(CNT_W)) bus ();

  power_sweep_ctrl #(.PASSES(PASSES), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 0 = correct sub-circuit, 1 = stuck-0, 2 = stuck-1, 3 = per-vector flips
  logic [1:0]  fault_kind;
  logic [15:0] flip_mask;
  logic [15:0] truth_tbl;
  int          gray_tbl[16];
  int          tests;
  int          fails;

  assign bus.dut_out_i = (fault_kind == 2'd1) ? 1'b0 :
                         (fault_kind == 2'd2) ? 1'b1 :
                         (fault_kind == 2'd3) ? (truth_tbl[bus.vec_o] ^ flip_mask[bus.vec_o]) :
                                                truth_tbl[bus.vec_o];

  task automatic check_eq(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int sub_ckt(input int v);
    case (fault_kind)
      2'd1:    return 0;
      2'd2:    return 1;
      2'd3:    return int'(truth_tbl[v] ^ flip_mask[v]);
      default: return int'(truth_tbl[v]);
    endcase
  endfunction

  function automatic int exp_vec(input int n, input logic md);
    return md ? gray_tbl[n % 16] : (n % 16);
  endfunction

  function automatic int sat(input int c);
    return (c > SATMAX) ? SATMAX : c;
  endfunction

  task automatic model_run(input logic md, output int e_ones, output int e_tog, output int e_mis);
    int prev;
    e_ones = 0; e_tog = 0; e_mis = 0; prev = 0;
    for (int n = 0; n < N; n++) begin
      int v, s;
      v = exp_vec(n, md);
      s = sub_ckt(v);
      e_ones += s;
      if (s != int'(truth_tbl[v])) e_mis++;
      if (n > 0 && s != prev) e_tog++;
      prev = s;
    end
    e_ones = sat(e_ones); e_tog = sat(e_tog); e_mis = sat(e_mis);
  endtask

  task automatic check_counts(input string tag, input int o, input int t, input int m);
    check_eq({tag, ".ones"},   int'(bus.ones_cnt_o),     o);
    check_eq({tag, ".toggle"}, int'(bus.toggle_cnt_o),   t);
    check_eq({tag, ".mism"},   int'(bus.mismatch_cnt_o), m);
  endtask

  // Entered at a negedge with the DUT idle; abort_at < 0 means run to completion.
  task automatic do_run(input logic md, input int ready_delay, input int abort_at);
    int e_ones, e_tog, e_mis;
    model_run(md, e_ones, e_tog, e_mis);
    bus.res_ready_i = (ready_delay == 0);
    bus.start_i = 1'b1;
    bus.mode_i  = md;
    step();
    bus.start_i = 1'b0;
    bus.mode_i  = 1'($urandom);
    for (int n = 0; n < N; n++) begin
      check_eq("run.valid", int'(bus.vec_valid_o), 1);
      check_eq("run.vec",   int'(bus.vec_o), exp_vec(n, md));
      check_eq("run.busy",  int'(bus.busy_o), 1);
      check_eq("run.done",  int'(bus.done_o), 0);
      if (n == abort_at) begin
        bus.abort_i = 1'b1;
        step();
        bus.abort_i = 1'b0;
        check_eq("abort.valid", int'(bus.vec_valid_o), 0);
        check_eq("abort.vec",   int'(bus.vec_o), 0);
        check_eq("abort.busy",  int'(bus.busy_o), 0);
        check_eq("abort.done",  int'(bus.done_o), 0);
        check_eq("abort.res",   int'(bus.res_valid_o), 0);
        check_counts("abort", 0, 0, 0);
        bus.res_ready_i = 1'b0;
        return;
      end
      step();
    end
    check_eq("drain.valid", int'(bus.vec_valid_o), 0);
    check_eq("drain.vec",   int'(bus.vec_o), 0);
    check_eq("drain.busy",  int'(bus.busy_o), 1);
    check_eq("drain.res",   int'(bus.res_valid_o), 0);
    step();
    check_eq("rep.res",  int'(bus.res_valid_o), 1);
    check_eq("rep.done", int'(bus.done_o), 1);
    check_eq("rep.busy", int'(bus.busy_o), 0);
    check_counts("rep", e_ones, e_tog, e_mis);
    for (int d = 0; d < ready_delay; d++) begin
      bus.start_i = 1'($urandom);
      step();
      check_eq("hold.res",  int'(bus.res_valid_o), 1);
      check_eq("hold.done", int'(bus.done_o), 0);
      check_eq("hold.busy", int'(bus.busy_o), 0);
      check_counts("hold", e_ones, e_tog, e_mis);
    end
    bus.start_i = 1'b0;
    bus.res_ready_i = 1'b1;
    step();
    bus.res_ready_i = 1'b0;
    check_eq("idle.res",  int'(bus.res_valid_o), 0);
    check_eq("idle.busy", int'(bus.busy_o), 0);
    check_eq("idle.done", int'(bus.done_o), 0);
    step();
    check_counts("idle", e_ones, e_tog, e_mis);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".valid"}, int'(bus.vec_valid_o), 0);
    check_eq({tag, ".vec"},   int'(bus.vec_o), 0);
    check_eq({tag, ".busy"},  int'(bus.busy_o), 0);
    check_eq({tag, ".done"},  int'(bus.done_o), 0);
    check_eq({tag, ".res"},   int'(bus.res_valid_o), 0);
    check_counts(tag, 0, 0, 0);
  endtask

  initial begin
    tests = 0; fails = 0;
    truth_tbl  = 16'h2CC2;
    gray_tbl   = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
    fault_kind = 2'd0;
    flip_mask  = 16'h0000;
    rst_n = 1'b0;
    bus.start_i = 1'b0; bus.mode_i = 1'b0; bus.abort_i = 1'b0; bus.res_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    do_run(1'b0, 0, -1);
    do_run(1'b1, 10, -1);
    fault_kind = 2'd1; do_run(1'b0, 3, -1);
    fault_kind = 2'd2; do_run(1'b1, 1, -1);
    fault_kind = 2'd0;

    bus.start_i = 1'b1; bus.abort_i = 1'b1;
    step();
    bus.start_i = 1'b0; bus.abort_i = 1'b0;
    check_eq("startabort.busy",  int'(bus.busy_o), 0);
    check_eq("startabort.valid", int'(bus.vec_valid_o), 0);

    do_run(1'b0, 2, 16 + 7);
    do_run(1'b0, 0, -1);

    bus.start_i = 1'b1; bus.mode_i = 1'b0;
    step();
    bus.start_i = 1'b0;
    repeat (10) step();
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_eq("postreset.busy", int'(bus.busy_o), 0);

    for (int r = 0; r < 12; r++) begin
      fault_kind = 2'($urandom_range(0, 3));
      flip_mask  = 16'($urandom);
      do_run(1'($urandom), int'($urandom_range(0, 5)),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/power_sweep_ctrl.md
# power_sweep_ctrl

Stimulus sequencer and activity counter for one 4-input power-characterisation sub-circuit. On a start request it drives every 16-entry input vector into the sub-circuit, in binary or Gray order, for PARAM-selected passes. It samples the sub-circuit output one cycle later and accumulates three counts: output ones, output toggles, and mismatches against a built-in golden model. Results are handed off through a valid/ready port, and the toggle counts feed switching-activity based power estimation.

## Interface
- PASSES, default 4: number of full 16-vector sweeps per run (1..255).
- CNT_W, default 8: width of each result counter; counters saturate.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  run request; honoured only in IDLE.
- mode_i  in  1  vector order: 0 = binary, 1 = Gray. Sampled with start_i and held for the run.
- abort_i  in  1  cancels any run; priority over all other inputs.
- vec_o  out  4  drives sub-circuit inputs: vec_o[0]=n_1, [1]=n_2, [2]=n_3, [3]=n_4.
- vec_valid_o  out  1  vec_o carries a live stimulus this cycle.
- dut_out_i  in  1  sub-circuit output n_8, combinational from vec_o.
- busy_o  out  1  high in RUN and DRAIN.
- done_o  out  1  one-cycle pulse on entry to REPORT.
- res_valid_o  out  1  results valid; held until accepted.
- res_ready_i  in  1  consumer accepts results.
- ones_cnt_o  out  CNT_W  count of sampled outputs equal to 1.
- toggle_cnt_o  out  CNT_W  count of sampled-output transitions within the run.
- mismatch_cnt_o  out  CNT_W  count of samples differing from the golden model.

## Operation
- States: IDLE, RUN, DRAIN, REPORT.
- IDLE, start_i=1: clear all counters, index, pass counter and sample history, latch mode_i, go to RUN.
- RUN: each cycle, issue the vector for index i (4 bits): vec = i in binary mode, vec = i ^ (i>>1) in Gray mode. Assert vec_valid_o and increment i.
  - At the wrap i: 15 -> 0, the pass counter increments.
  - After the 16*PASSES-th vector, go to DRAIN.
- DRAIN: one cycle, vec_valid_o=0; the final sample is taken. Then go to REPORT.
- REPORT: res_valid_o=1 and counters frozen. On res_valid_o & res_ready_i, go to IDLE. start_i is ignored in this state.
- Sample pipeline: the vector applied in cycle t, together with the golden model computed from it, is compared against dut_out_i in cycle t.
  - The result is registered in a sample stage and counted in cycle t+1.
  - Golden model: exp = ~(v[1]^v[2]^v[3]) & (v[0]|v[1]).
- Count rules:
  - ones +1 when the sample is 1.
  - mismatch +1 when the sample differs from exp.
  - toggle +1 when the sample differs from the previous sample of the same run. The first sample of a run never toggles; pass boundaries are not special.
- All counters saturate at 2^CNT_W-1 with no wrap.
- abort_i in any state: go to IDLE next cycle, drop vec_valid_o/busy_o/res_valid_o, clear counters. No done_o pulse.
- vec_o is 0 whenever vec_valid_o=0.

## Timing
- Reset (async assert, sync-deasserted at system level): state IDLE; every output 0.
- start_i sampled high at edge k:
  - vectors are presented in cycles k+1 .. k+N, where N = 16*PASSES;
  - DRAIN occurs at cycle k+N+1;
  - REPORT, with res_valid_o=1 and done_o=1, starts at k+N+2.
- Total start-to-result latency: N+2 cycles. done_o is high for exactly one cycle.
- Result handshake: transfer on the cycle where res_valid_o & res_ready_i.
  - If res_ready_i is already high on REPORT entry, res_valid_o lasts one cycle and IDLE follows.
  - Counter outputs hold their values through IDLE until the next accepted start.
- A new start is accepted at the earliest in the cycle after returning to IDLE. start_i asserted with abort_i is ignored.
- abort_i mid-RUN: no further vec_valid_o from the next cycle. An in-flight sample is discarded.

## Test plan
- Binary sweep, PASSES=1, dut_out_i driven by a correct sub-circuit: N=16 -> res_valid at start+18; ones=6, toggles=8, mismatch=0.
- Gray sweep, PASSES=4, correct sub-circuit: vec_o sequence 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8 repeated -> ones=24, toggles=32, mismatch=0, done_o single pulse.
- dut_out_i stuck at 0, binary, PASSES=4 -> ones=0, toggles=0, mismatch=24.
- dut_out_i stuck at 1, PASSES=16, CNT_W=8 -> ones saturates at 255 (not 256 -> 0), toggles=0, mismatch=160.
- abort_i at vector 7 of pass 2 -> vec_valid_o low next cycle, counters 0, no done_o. An immediately following start runs a clean full sweep with correct counts.
- Handshake: hold res_ready_i=0 for 10 cycles in REPORT -> res_valid_o and counts stable, start_i pulses ignored. res_ready_i=1 -> IDLE next cycle. Apply async rst_n low mid-RUN -> all outputs 0 immediately.
